// File: rtl/clk_period_meas_pkg.sv
// rtl/clk_period_meas_pkg.sv - shared constants, FSM states and Gray helpers for clk_period_meas
//
// Contents:
//   DEF_LEN_W, DEF_CNT_W, DEF_SYNC_STAGES  default parameter values
//   GRAY_MAX_W                             widest counter the Gray helpers handle
//   meas_state_e                           window FSM states
//   bin2gray / gray2bin                    conversions on zero-extended values
package clk_period_meas_pkg;

    localparam int DEF_LEN_W       = 24;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_SYNC_STAGES = 2;

    // Callers zero-extend into this width and truncate the result back.
    // Zero upper bits leave the low bits of either conversion unchanged.
    localparam int GRAY_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } meas_state_e;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/clk_period_meas_xclk_strobe.sv
// rtl/clk_period_meas_xclk_strobe.sv - single-cycle strobe transfer between unrelated clocks
//
// A source pulse flips a toggle flop. The destination synchronizes the toggle
// and turns each observed change back into a one-cycle pulse. Source pulses
// must be spaced far enough apart for the destination to see every toggle.
//
// Ports:
//   rst_i      asynchronous active-high reset, both domains
//   clk_src_i  source clock
//   pulse_i    single-cycle strobe in the source domain
//   clk_dst_i  destination clock
//   pulse_o    single-cycle registered strobe in the destination domain
module clk_period_meas_xclk_strobe
    import clk_period_meas_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic rst_i,
    input  logic clk_src_i,
    input  logic pulse_i,
    input  logic clk_dst_i,
    output logic pulse_o
);

    logic                   tgl_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   seen_q;
    logic                   pulse_q;

    always_ff @(posedge clk_src_i or posedge rst_i) begin
        if (rst_i) begin
            tgl_q <= 1'b0;
        end else if (pulse_i) begin
            tgl_q <= ~tgl_q;
        end
    end

    always_ff @(posedge clk_dst_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            seen_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], tgl_q};
            seen_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] ^ seen_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/clk_period_meas.sv
// rtl/clk_period_meas.sv - reciprocal frequency counter: clk_ref ticks over cmd_len+1 clk_meas periods
//
// Optional build macro: CLK_PMEAS_CONT_EN (back-to-back windows with zero dead time
// after the first start; a further start ends the run after the current window).
//
// Ports:
//   clk_meas  measured clock, runs the window FSM
//   rst       asynchronous active-high reset for every domain
//   clk_ref   reference clock feeding the free-running tick counter
//   clk       control-interface clock
//   cmd_len   window length minus one, held by the host until resp_stb
//   cmd_stb   single-cycle start strobe (clk)
//   resp_cnt  clk_ref ticks counted in the last window, stable after resp_stb
//   resp_stb  single-cycle result strobe (clk)
module clk_period_meas
    import clk_period_meas_pkg::*;
#(
    parameter int LEN_W       = DEF_LEN_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk_meas,
    input  logic             rst,
    input  logic             clk_ref,
    input  logic             clk,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_stb,
    output logic [CNT_W-1:0] resp_cnt,
    output logic             resp_stb
);

    // ------------------------------------------------------------------
    // clk_ref domain: free-running counter plus registered Gray copy, so
    // only one bit of the crossing bus changes per reference tick.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] ref_bin_q;
    logic [CNT_W-1:0] ref_gray_q;
    logic [CNT_W-1:0] ref_gray_d;

    assign ref_gray_d = CNT_W'(bin2gray(GRAY_MAX_W'(ref_bin_q)));

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            ref_bin_q  <= '0;
            ref_gray_q <= '0;
        end else begin
            ref_bin_q  <= ref_bin_q + CNT_W'(1);
            ref_gray_q <= ref_gray_d;
        end
    end

    // ------------------------------------------------------------------
    // Crossing into clk_meas: synchronizer chain, decode, register.
    // The fixed pipeline lag is common to S and E and cancels in E - S.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] ref_sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] ref_now_d;
    logic [CNT_W-1:0] ref_now_q;

    assign ref_now_d = CNT_W'(gray2bin(GRAY_MAX_W'(ref_sync_q[SYNC_STAGES-1])));

    always_ff @(posedge clk_meas or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ref_sync_q[i] <= '0;
            end
            ref_now_q <= '0;
        end else begin
            ref_sync_q[0] <= ref_gray_q;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ref_sync_q[i] <= ref_sync_q[i-1];
            end
            ref_now_q <= ref_now_d;
        end
    end

    // ------------------------------------------------------------------
    // Start strobe into clk_meas
    // ------------------------------------------------------------------
    logic meas_start;

    clk_period_meas_xclk_strobe #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cmd_xclk (
        .rst_i     (rst),
        .clk_src_i (clk),
        .pulse_i   (cmd_stb),
        .clk_dst_i (clk_meas),
        .pulse_o   (meas_start)
    );

    // ------------------------------------------------------------------
    // Window FSM (clk_meas). S is taken on the start edge; E is taken
    // cmd_len+1 edges later when len_cnt has counted down to zero.
    // ------------------------------------------------------------------
    meas_state_e      state_q;
    logic [LEN_W-1:0] len_cnt_q;
    logic [CNT_W-1:0] s_q;
    logic [CNT_W-1:0] e_q;
    logic [CNT_W-1:0] resp_q;
    logic             done_q;
`ifdef CLK_PMEAS_CONT_EN
    logic             cont_q;
`endif

    always_ff @(posedge clk_meas or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_cnt_q <= '0;
            s_q       <= '0;
            e_q       <= '0;
            resp_q    <= '0;
            done_q    <= 1'b0;
`ifdef CLK_PMEAS_CONT_EN
            cont_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (meas_start) begin
                        s_q       <= ref_now_q;
                        len_cnt_q <= cmd_len;
                        state_q   <= ST_RUN;
`ifdef CLK_PMEAS_CONT_EN
                        cont_q    <= 1'b1;
`endif
                    end
                end
                ST_RUN: begin
`ifdef CLK_PMEAS_CONT_EN
                    // A start while running requests the end of the run;
                    // the window in progress still completes.
                    if (meas_start) begin
                        cont_q <= 1'b0;
                    end
`endif
                    if (len_cnt_q == '0) begin
                        e_q <= ref_now_q;
`ifdef CLK_PMEAS_CONT_EN
                        if (cont_q && !meas_start) begin
                            // This E is the next window's S; result and
                            // reload happen here so no clk_meas edge is lost.
                            s_q       <= ref_now_q;
                            resp_q    <= ref_now_q - s_q;
                            done_q    <= 1'b1;
                            len_cnt_q <= cmd_len;
                        end else begin
                            state_q <= ST_DONE;
                        end
`else
                        state_q <= ST_DONE;
`endif
                    end else begin
                        len_cnt_q <= len_cnt_q - LEN_W'(1);
                    end
                end
                ST_DONE: begin
                    // Modular subtraction keeps the count right across a wrap.
                    resp_q  <= e_q - s_q;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result strobe back to clk. resp_q only changes when a new result is
    // produced, so it is stable by the time resp_stb is seen.
    // ------------------------------------------------------------------
    clk_period_meas_xclk_strobe #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_done_xclk (
        .rst_i     (rst),
        .clk_src_i (clk_meas),
        .pulse_i   (done_q),
        .clk_dst_i (clk),
        .pulse_o   (resp_stb)
    );

    assign resp_cnt = resp_q;

endmodule

// File: tb/tb_clk_period_meas.sv
// tb/tb_clk_period_meas.sv - scoreboard bench for clk_period_meas (default and CLK_PMEAS_CONT_EN builds)
module tb_clk_period_meas;

    localparam int LEN_W  = 24;
    localparam int CNT_W  = 32;
    localparam int CNT8_W = 8;

    logic              clk_meas = 1'b0;
    logic              clk_ref  = 1'b0;
    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic [LEN_W-1:0]  cmd_len  = '0;
    logic              cmd_stb  = 1'b0;
    logic              cmd_stb8 = 1'b0;
    logic [CNT_W-1:0]  resp_cnt;
    logic              resp_stb;
    logic [CNT8_W-1:0] resp_cnt8;
    logic              resp_stb8;

    int meas_half = 500;

    int total = 0;
    int bad   = 0;

    string  q_tag[$];
    longint q_nom[$];
    string  q8_tag[$];
    longint q8_nom[$];

    int     stb_cnt  = 0;
    int     stb8_cnt = 0;
    longint sum10    = 0;
    longint stb_t[$];

    // 10 MHz reference (period 100), control clock period 32, measured clock variable.
    initial begin #7; forever #50 clk_ref = ~clk_ref; end
    initial begin #3; forever #(meas_half) clk_meas = ~clk_meas; end
    initial begin forever #16 clk = ~clk; end

    clk_period_meas #(
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_meas (clk_meas),
        .rst      (rst),
        .clk_ref  (clk_ref),
        .clk      (clk),
        .cmd_len  (cmd_len),
        .cmd_stb  (cmd_stb),
        .resp_cnt (resp_cnt),
        .resp_stb (resp_stb)
    );

    clk_period_meas #(
        .LEN_W (LEN_W),
        .CNT_W (CNT8_W)
    ) dut8 (
        .clk_meas (clk_meas),
        .rst      (rst),
        .clk_ref  (clk_ref),
        .clk      (clk),
        .cmd_len  (cmd_len),
        .cmd_stb  (cmd_stb8),
        .resp_cnt (resp_cnt8),
        .resp_stb (resp_stb8)
    );

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
        total++;
        if (obs < exp - tol || obs > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic push(input string tag, input longint nom);
        q_tag.push_back(tag);
        q_nom.push_back(nom);
    endtask

    task automatic push8(input string tag, input longint nom);
        q8_tag.push_back(tag);
        q8_nom.push_back(nom);
    endtask

    task automatic pulse_cmd(input bit eight);
        @(posedge clk); #1;
        if (eight) cmd_stb8 = 1'b1;
        else       cmd_stb  = 1'b1;
        @(posedge clk); #1;
        cmd_stb  = 1'b0;
        cmd_stb8 = 1'b0;
    endtask

    task automatic wait_stb(input string tag, input bit eight, input int n, input int max_cyc);
        for (int i = 0; i < max_cyc && (eight ? stb8_cnt : stb_cnt) < n; i++) begin
            @(posedge clk);
        end
        #1;
        check({tag, "_stb"}, eight ? stb8_cnt : stb_cnt, n, 0);
    endtask

    always @(negedge clk) begin
        if (resp_stb) begin
            stb_cnt++;
            stb_t.push_back($time);
            if (stb_cnt <= 10) sum10 += longint'(resp_cnt);
            if (q_nom.size() == 0) check("stray_stb", 1, 0, 0);
            else check(q_tag.pop_front(), longint'(resp_cnt), q_nom.pop_front(), 1);
        end
        if (resp_stb8) begin
            stb8_cnt++;
            if (q8_nom.size() == 0) check("stray_stb8", 1, 0, 0);
            else check(q8_tag.pop_front(), longint'(resp_cnt8), q8_nom.pop_front(), 1);
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt",  resp_cnt,  0, 0);
        check("rst_stb",  resp_stb,  0, 0);
        check("rst_cnt8", resp_cnt8, 0, 0);
        check("rst_stb8", resp_stb8, 0, 0);
        rst = 1'b0;

`ifdef CLK_PMEAS_CONT_EN
        // 20 MHz measured clock, 2000-period windows = 100000 time units each.
        meas_half = 25;
        cmd_len   = 24'd1999;
        for (int i = 0; i < 10; i++) push("cont", 1000);
        pulse_cmd(0);
        wait_stb("cont10", 0, 10, 40000);
        push("cont_last", 1000);
        pulse_cmd(0);
        wait_stb("cont11", 0, 11, 5000);
        repeat (8000) @(posedge clk);
        check("cont_stop", stb_cnt, 11, 0);
        check("cont_sum", sum10, 10000, 1);
        for (int i = 1; i < 10 && i < stb_t.size(); i++) begin
            check("cont_period", stb_t[i] - stb_t[i-1], 100000, 100);
        end
`else
        // 8-bit counter: start near count 230 so the 100-tick window wraps.
        meas_half = 500;
        cmd_len   = 24'd9;
        repeat (210) @(posedge clk_ref);
        push8("wrap8", 100);
        pulse_cmd(1);
        wait_stb("wrap8", 1, 1, 2000);

        // 1 MHz: ten periods, then a single period.
        push("len9", 100);
        pulse_cmd(0);
        wait_stb("len9", 0, 1, 2000);
        cmd_len = 24'd0;
        push("len0", 10);
        pulse_cmd(0);
        wait_stb("len0", 0, 2, 2000);

        // 25 MHz, 25000 periods = 1 ms.
        meas_half = 20;
        cmd_len   = 24'd24999;
        push("len24999", 10000);
        pulse_cmd(0);
        wait_stb("len24999", 0, 3, 40000);

        // Second start during RUN is ignored.
        meas_half = 500;
        cmd_len   = 24'd9;
        push("dbl", 100);
        pulse_cmd(0);
        repeat (125) @(posedge clk);
        pulse_cmd(0);
        wait_stb("dbl", 0, 4, 2000);
        repeat (700) @(posedge clk);
        check("dbl_once", stb_cnt, 4, 0);

        // Reset for three clk cycles in the middle of a window.
        pulse_cmd(0);
        repeat (190) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (700) @(posedge clk);
        check("rst_nostb", stb_cnt, 4, 0);
        check("rst_cnt0", resp_cnt, 0, 0);
        push("after_rst", 100);
        pulse_cmd(0);
        wait_stb("after_rst", 0, 5, 2000);
`endif
        check("q_empty",  q_nom.size(),  0, 0);
        check("q8_empty", q8_nom.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
